// File: rtl/result_writeback.sv
// Captures the engine's result vector on a rising edge of capture and writes it to memory over Avalon-MM.
// Optional: define RESULT_WB_CSUM_EN to append a checksum beat after the results.
module result_writeback #(
    parameter int          NUM_RESULTS  = 8,
    parameter int          RESULT_WIDTH = 24,
    parameter logic [31:0] BASE_ADDR    = 32'd16,
    parameter logic [31:0] ADDR_STRIDE  = 32'd1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    capture,
    input  logic [RESULT_WIDTH-1:0] c_in [0:NUM_RESULTS-1],
    output logic [31:0]             mm_address,
    output logic                    mm_write,
    output logic [63:0]             mm_writedata,
    output logic [7:0]              mm_byteenable,
    input  logic                    mm_waitrequest,
    output logic                    busy,
    output logic                    wb_done,
    output logic [3:0]              wb_count
);
`ifdef RESULT_WB_CSUM_EN
    localparam int BEATS = NUM_RESULTS + 1;
`else
    localparam int BEATS = NUM_RESULTS;
`endif
    localparam int IW = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;

    state_t                  state, state_n;
    logic                    capture_q;
    logic [RESULT_WIDTH-1:0] snap [0:NUM_RESULTS-1];
    logic [IW-1:0]           idx, idx_n, sel;
    logic [63:0]             sel_data;
    logic                    snap_load, trigger;
    logic [31:0]             addr_n;
    logic                    write_n, busy_n, done_n;
    logic [63:0]             data_n;
    logic [7:0]              be_n;
    logic [3:0]              count_n;

`ifdef RESULT_WB_CSUM_EN
    logic [31:0] csum, sum_in;

    always_comb begin
        sum_in = '0;
        for (int i = 0; i < NUM_RESULTS; i++) sum_in = sum_in + 32'(c_in[i]);
    end
`endif

    assign trigger = capture && !capture_q;
    assign sel     = idx + IW'(1);

    // Data for the beat that follows the one currently on the bus.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_RESULTS; i++)
            if (sel == IW'(i)) sel_data = 64'(snap[i]);
`ifdef RESULT_WB_CSUM_EN
        if (sel == IW'(NUM_RESULTS)) sel_data = {32'd0, csum};
`endif
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        addr_n    = mm_address;
        write_n   = mm_write;
        data_n    = mm_writedata;
        be_n      = mm_byteenable;
        busy_n    = busy;
        done_n    = wb_done;
        count_n   = wb_count;
        snap_load = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_n   = WRITE;
                    idx_n     = '0;
                    addr_n    = BASE_ADDR;
                    write_n   = 1'b1;
                    data_n    = 64'(c_in[0]);
                    be_n      = 8'hFF;
                    busy_n    = 1'b1;
                    done_n    = 1'b0;
                    count_n   = '0;
                    snap_load = 1'b1;
                end
            end
            WRITE: begin
                if (!mm_waitrequest) begin
                    count_n = wb_count + 4'd1;
                    if (idx == IW'(BEATS - 1)) begin
                        state_n = FINISH;
                        write_n = 1'b0;
                        be_n    = 8'h00;
                        busy_n  = 1'b0;
                    end else begin
                        idx_n  = sel;
                        addr_n = mm_address + ADDR_STRIDE;
                        data_n = sel_data;
                    end
                end
            end
            FINISH: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            capture_q     <= 1'b0;
            idx           <= '0;
            mm_address    <= '0;
            mm_write      <= 1'b0;
            mm_writedata  <= '0;
            mm_byteenable <= '0;
            busy          <= 1'b0;
            wb_done       <= 1'b0;
            wb_count      <= '0;
        end else begin
            state         <= state_n;
            capture_q     <= capture;
            idx           <= idx_n;
            mm_address    <= addr_n;
            mm_write      <= write_n;
            mm_writedata  <= data_n;
            mm_byteenable <= be_n;
            busy          <= busy_n;
            wb_done       <= done_n;
            wb_count      <= count_n;
        end
    end

    // Results are frozen at the trigger so later engine activity cannot leak into the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RESULTS; i++) snap[i] <= '0;
`ifdef RESULT_WB_CSUM_EN
            csum <= '0;
`endif
        end else if (snap_load) begin
            for (int i = 0; i < NUM_RESULTS; i++) snap[i] <= c_in[i];
`ifdef RESULT_WB_CSUM_EN
            csum <= sum_in;
`endif
        end
    end
endmodule

// File: doc/result_writeback.md
Name: result_writeback

Overview:
- Downstream consumer of the matrix-vector engine.
- On a rising edge of the engine's done flag, snapshots the 8 result values C[0..7] (24-bit each).
- Writes the results back into memory through an Avalon-MM write master port, one 64-bit word per result.
- Lets software or the next pass read results from memory instead of from the MAC accumulators.

Parameters:
- NUM_RESULTS, 8, number of result words captured and written.
- RESULT_WIDTH, 24, width of each incoming result; zero-extended to 64 bits on the bus.
- BASE_ADDR, 32'd16, word address of the first result write.
- ADDR_STRIDE, 32'd1, address increment between consecutive result writes.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous assert, active-low, synchronous to clk on release
- capture  input  1  level input (engine done); a rising edge triggers a writeback
- c_in  input  [RESULT_WIDTH-1:0] x NUM_RESULTS (unpacked [0:7])  result vector from engine
- mm_address  output  32  Avalon-MM word address
- mm_write  output  1  Avalon-MM write request
- mm_writedata  output  64  Avalon-MM write data
- mm_byteenable  output  8  always 8'hFF while mm_write is high, 8'h00 otherwise
- mm_waitrequest  input  1  slave stall; a beat is accepted on any cycle with mm_write=1 and mm_waitrequest=0
- busy  output  1  high from the cycle after the trigger until the last beat is accepted
- wb_done  output  1  sticky completion flag
- wb_count  output  4  number of beats accepted in the current or last writeback

Behaviour:
- Reset values: state=IDLE, mm_address=0, mm_write=0, mm_writedata=0, mm_byteenable=0, busy=0, wb_done=0, wb_count=0, capture_q=0, snapshot registers=0.
- Edge detect: capture_q is a registered copy of capture. The trigger is capture && !capture_q, evaluated at each posedge.
- States:
  - IDLE: on trigger, latch all c_in into snapshot registers at the same edge, clear wb_done and wb_count, set idx=0, go to WRITE.
  - WRITE: mm_write=1, mm_address=BASE_ADDR+idx*ADDR_STRIDE, mm_writedata={zero-fill, snapshot[idx]}.
    - Outputs are registered; they are presented the cycle after the trigger edge.
    - Address and data are held stable while mm_waitrequest=1.
    - On an accepted beat: idx++ and wb_count++ at that edge, and the next beat is presented the following cycle (mm_write stays high, back-to-back).
    - When the accepted beat is the last one (idx==NUM_RESULTS-1): go to FINISH.
  - FINISH: mm_write=0, busy=0, wb_done=1 at this edge, then go to IDLE. wb_done stays high in IDLE until the next trigger or reset.
- Latency: with mm_waitrequest tied 0, the trigger is at edge T, beats are accepted at edges T+1..T+8, and wb_done is high after edge T+9.
- Snapshot: results are frozen at the trigger. Changes on c_in during WRITE do not affect written data.
- Retrigger during WRITE or FINISH (capture falls and rises again): ignored. No queueing; capture_q still tracks capture.
- capture held high continuously: exactly one writeback.
- capture high out of reset: capture_q resets to 0, so the first clock edge after reset release counts as a rising edge and triggers a writeback.
- Reset mid-write: all outputs return to their reset values immediately (asynchronous); the partial transfer is abandoned. No resume after release.
- Address arithmetic: 32-bit, wraps modulo 2^32 with no error.
- busy and wb_done are never high simultaneously.

Optional Feature:
- Macro: RESULT_WB_CSUM_EN.
- Defined:
  - After the last result beat, one extra beat is written to BASE_ADDR+NUM_RESULTS*ADDR_STRIDE.
  - Data is {32'd0, sum}, where sum is the 32-bit modulo sum of all snapshot values, computed at snapshot time.
  - Total beats = NUM_RESULTS+1, and wb_count reaches 9.
  - FINISH is entered only after the checksum beat is accepted.
- Undefined: no checksum logic, exactly NUM_RESULTS beats.

Test Plan:
- Basic writeback:
  - Stimulus: c_in = {1,2,...,8}, mm_waitrequest=0, capture rises.
  - Required: 8 back-to-back beats at addresses 16..23 with data 64'd1..64'd8, byteenable 8'hFF; wb_done=1 and wb_count=8 one cycle after the last beat.
- Stall handling:
  - Stimulus: mm_waitrequest=1 for 3 cycles on beat 0 and 2 cycles on beat 5.
  - Required: address and data held constant during each stall; all 8 beats are written exactly once; total writeback spans 13 cycles.
- Snapshot and retrigger:
  - Stimulus: change c_in to all 24'hFFFFFF during WRITE; pulse capture low then high during WRITE; hold capture high afterwards.
  - Required: the original values are written; only one writeback occurs; no second writeback starts while capture stays high.
- Max values and width:
  - Stimulus: c_in all 24'hFFFFFF.
  - Required: writedata = 64'h0000_0000_00FF_FFFF for each beat.
  - With RESULT_WB_CSUM_EN: 9th beat at address 24 with data 64'h0000_0000_07FF_FFF8.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 after beat 3 is accepted.
  - Required: mm_write, busy, wb_done and wb_count drop to 0 immediately.
  - Stimulus: release reset, then raise capture again.
  - Required: a full 8-beat writeback from address 16.
